alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 alu_op  input  2  00 ADD, 01 SUB, 10 R-type (use func), 11 I-type (use opcode).
REQ-009 opcode  input  6  instruction opcode.
REQ-010 func  input  6  R-type function field.
REQ-011 op_a, op_b  input  WIDTH each  operands.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 result  output  WIDTH  operation result.
REQ-015 alu_ctrl  output  4  latched decoded function code.
REQ-016 illegal  output  1  latched request had an undecodable func/opcode.

Function
REQ-017 SHALL use alu_ctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SEQ, 9 SNE, A SLT, B SLE, C SGT, D SGE, E LHI, F NOP.
REQ-018 SHALL decode R-type func (hex): 04,06,08,09,0A,0C,0E,0F,10,12,14,16,18,1A to codes 0..D in that order; 00 to F.
REQ-019 SHALL decode I-type opcode as R-type func + 6'h10 for codes 0..D, and 6'h1B to E.
REQ-020 SHALL treat any other func/opcode as illegal: alu_ctrl = F, illegal = 1, result = 0; no X is ever driven.
REQ-021 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE; in_ready = (state == IDLE).
REQ-022 SHALL, on in_valid & in_ready, latch operands and decoded code and go IDLE->EXEC.
REQ-023 SHALL, in EXEC, compute non-shift ops, store the result, and go to DONE; out_valid rises the cycle after EXEC.
REQ-024 SHALL use shift amount op_b[SHW-1:0]; SRA sign-fills from bit WIDTH-1.
REQ-025 SHALL compute SEQ..SGE as signed two's-complement compares with result 1 or 0, zero-extended.
REQ-026 SHALL compute LHI as op_b << (WIDTH/2); NOP yields result 0 with illegal = 0.
REQ-027 SHALL compute ADD/SUB modulo 2^WIDTH with no overflow flag.
REQ-028 SHALL hold result, alu_ctrl, illegal and out_valid stable in DONE until out_valid & out_ready, then go to IDLE.
REQ-029 SHALL ignore in_valid outside IDLE; no request is accepted in the DONE->IDLE handoff cycle.

Reset
REQ-030 SHALL, on reset (including mid-operation, in any state), go to IDLE and clear out_valid, result, alu_ctrl, illegal and the shift counter to 0; in_ready = 1 in the first cycle after reset.

Configuration
REQ-031 SHALL honour macro ALU_SERIAL_SHIFT_EN.
REQ-032 With ALU_SERIAL_SHIFT_EN defined, SLL/SRL/SRA with amount k > 0 go EXEC->SHIFT and shift one bit per cycle for k cycles, then go to DONE; k = 0 goes EXEC->DONE.
REQ-033 With ALU_SERIAL_SHIFT_EN undefined, shifts use a single-cycle barrel shifter in EXEC, SHIFT is unreachable, and every op has latency identical to ADD.

Verification
REQ-034 WIDTH=32, alu_op=10, func=04, A=7, B=5, out_ready=1 -> alu_ctrl=0, result=12, out_valid asserted two edges after acceptance.
REQ-035 alu_op=11, opcode=24 (SLTI), A=32'hFFFFFFFF, B=1 -> alu_ctrl=A, result=1.
REQ-036 ALU_SERIAL_SHIFT_EN on, func=0F, A=32'h80000000, B=4 -> result=32'hF8000000, 4 SHIFT cycles, in_ready low throughout.
REQ-037 alu_op=10, func=3F -> illegal=1, alu_ctrl=F, result=0; out_ready held low 5 cycles -> outputs stable, then accepted on out_ready.
REQ-038 Reset asserted during SHIFT -> next cycle state IDLE, out_valid=0, in_ready=1; the following request completes normally.
REQ-039 WIDTH=16, opcode=1B, B=16'h00AB -> result=16'hAB00.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle for alu_exec_unit.
// master drives requests and takes results; slave is the execution unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_ctrl;
    logic             illegal;

    modport master (
        output in_valid, alu_op, opcode, func, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, alu_ctrl, illegal
    );

    modport slave (
        input  in_valid, alu_op, opcode, func, op_a, op_b, out_ready,
        output in_ready, out_valid, result, alu_ctrl, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: decode on accept, execute, hold result until taken.
// ALU_SERIAL_SHIFT_EN selects a one-bit-per-cycle shifter instead of a barrel.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q, res_q, alu_y;
    logic [3:0]       ctrl_q, dec_ctrl;
    logic             ill_q, dec_ill;
    logic             accept, serial_go, cmp;
    logic [SHW-1:0]   shamt;

    // {illegal, code}
    function automatic logic [4:0] dec_r(input logic [5:0] f);
        case (f)
            6'h04:   dec_r = 5'h00;
            6'h06:   dec_r = 5'h01;
            6'h08:   dec_r = 5'h02;
            6'h09:   dec_r = 5'h03;
            6'h0A:   dec_r = 5'h04;
            6'h0C:   dec_r = 5'h05;
            6'h0E:   dec_r = 5'h06;
            6'h0F:   dec_r = 5'h07;
            6'h10:   dec_r = 5'h08;
            6'h12:   dec_r = 5'h09;
            6'h14:   dec_r = 5'h0A;
            6'h16:   dec_r = 5'h0B;
            6'h18:   dec_r = 5'h0C;
            6'h1A:   dec_r = 5'h0D;
            6'h00:   dec_r = 5'h0F;
            default: dec_r = 5'h1F;
        endcase
    endfunction

    function automatic logic [4:0] dec_i(input logic [5:0] o);
        case (o)
            6'h14:   dec_i = 5'h00;
            6'h16:   dec_i = 5'h01;
            6'h18:   dec_i = 5'h02;
            6'h19:   dec_i = 5'h03;
            6'h1A:   dec_i = 5'h04;
            6'h1C:   dec_i = 5'h05;
            6'h1E:   dec_i = 5'h06;
            6'h1F:   dec_i = 5'h07;
            6'h20:   dec_i = 5'h08;
            6'h22:   dec_i = 5'h09;
            6'h24:   dec_i = 5'h0A;
            6'h26:   dec_i = 5'h0B;
            6'h28:   dec_i = 5'h0C;
            6'h2A:   dec_i = 5'h0D;
            6'h1B:   dec_i = 5'h0E;
            default: dec_i = 5'h1F;
        endcase
    endfunction

    always_comb begin
        dec_ctrl = 4'hF;
        dec_ill  = 1'b0;
        case (bus.alu_op)
            2'b00:   dec_ctrl = 4'h0;
            2'b01:   dec_ctrl = 4'h1;
            2'b10:   {dec_ill, dec_ctrl} = dec_r(bus.func);
            default: {dec_ill, dec_ctrl} = dec_i(bus.opcode);
        endcase
    end

    assign accept = bus.in_valid && (state == IDLE);
    assign shamt  = b_q[SHW-1:0];

    always_comb begin
        cmp = 1'b0;
        case (ctrl_q)
            4'h8:    cmp = (a_q == b_q);
            4'h9:    cmp = (a_q != b_q);
            4'hA:    cmp = ($signed(a_q) <  $signed(b_q));
            4'hB:    cmp = ($signed(a_q) <= $signed(b_q));
            4'hC:    cmp = ($signed(a_q) >  $signed(b_q));
            4'hD:    cmp = ($signed(a_q) >= $signed(b_q));
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (ctrl_q)
            4'h0:    alu_y = a_q + b_q;
            4'h1:    alu_y = a_q - b_q;
            4'h2:    alu_y = a_q & b_q;
            4'h3:    alu_y = a_q | b_q;
            4'h4:    alu_y = a_q ^ b_q;
            4'h5:    alu_y = a_q << shamt;
            4'h6:    alu_y = a_q >> shamt;
            4'h7:    alu_y = $signed(a_q) >>> shamt;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD:
                     alu_y = {{(WIDTH-1){1'b0}}, cmp};
            4'hE:    alu_y = b_q << (WIDTH / 2);
            default: alu_y = '0;
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] step;

    assign serial_go = (ctrl_q inside {4'h5, 4'h6, 4'h7}) && (shamt != '0);

    always_comb begin
        step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        case (ctrl_q)
            4'h5:    step = res_q << 1;
            4'h6:    step = res_q >> 1;
            default: step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state == EXEC && serial_go)
            cnt <= shamt;
        else if (state == SHIFT)
            cnt <= cnt - 1'b1;
    end
`else
    assign serial_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (bus.in_valid) state_n = EXEC;
            EXEC:  state_n = serial_go ? SHIFT : DONE;
            SHIFT: begin
`ifdef ALU_SERIAL_SHIFT_EN
                if (cnt == SHW'(1)) state_n = DONE;
`else
                state_n = DONE;
`endif
            end
            DONE:  if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            ctrl_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= bus.op_a;
                b_q    <= bus.op_b;
                ctrl_q <= dec_ctrl;
                ill_q  <= dec_ill;
            end
            // Serial shifts seed the result with op_a and walk it bit by bit
            if (state == EXEC)
                res_q <= serial_go ? a_q : alu_y;
`ifdef ALU_SERIAL_SHIFT_EN
            if (state == SHIFT)
                res_q <= step;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit against a spec-level reference model.
// Honours ALU_SERIAL_SHIFT_EN for expected shift latency.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit_if #(.WIDTH(16)) bus16 ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    alu_exec_unit #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    localparam logic [5:0] FTAB [14] = '{
        6'h04, 6'h06, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0E,
        6'h0F, 6'h10, 6'h12, 6'h14, 6'h16, 6'h18, 6'h1A
    };

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic started = 1'b0;
    logic m_busy = 1'b0;
    logic [3:0]  m_ctrl;
    logic        m_ill;
    logic [31:0] m_res;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(
        input  logic [1:0]  op,
        input  logic [5:0]  opc,
        input  logic [5:0]  fn,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [3:0]  c,
        output logic        ill,
        output logic [31:0] r
    );
        int sh;
        c = 4'hF;
        ill = 1'b0;
        r = 32'd0;
        if (op == 2'b00) c = 4'h0;
        else if (op == 2'b01) c = 4'h1;
        else if (op == 2'b10) begin
            if (fn != 6'h00) begin
                ill = 1'b1;
                for (int i = 0; i < 14; i++)
                    if (FTAB[i] == fn) begin c = 4'(i); ill = 1'b0; end
            end
        end else begin
            if (opc == 6'h1B) c = 4'hE;
            else begin
                ill = 1'b1;
                for (int i = 0; i < 14; i++)
                    if (FTAB[i] + 6'h10 == opc) begin c = 4'(i); ill = 1'b0; end
            end
        end
        if (ill) c = 4'hF;
        sh = int'(b % 32);
        case (c)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << sh;
            4'h6: r = a >> sh;
            4'h7: r = $signed(a) >>> sh;
            4'h8: r = (a == b) ? 32'd1 : 32'd0;
            4'h9: r = (a != b) ? 32'd1 : 32'd0;
            4'hA: r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'hB: r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
            4'hC: r = ($signed(a) >  $signed(b)) ? 32'd1 : 32'd0;
            4'hD: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'hE: r = b << 16;
            default: r = 32'd0;
        endcase
    endfunction

    // Cycle-by-cycle output check against the model's pending transaction
    always @(negedge clk) begin
        if (started) begin
            if (m_busy) chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (!m_busy) chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                chk("result", bus.result, m_res);
                chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_ctrl));
                chk("illegal", 32'(bus.illegal), 32'(m_ill));
            end
        end
    end

    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.alu_op = v.op;
        bus.opcode = v.opc;
        bus.func = v.fn;
        bus.op_a = v.a;
        bus.op_b = v.b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model(v.op, v.opc, v.fn, v.a, v.b, m_ctrl, m_ill, m_res);
        m_busy = 1'b1;
    endtask

    task automatic run(input vec_t v);
        int lat, el;
        issue(v);
        el = 2;
`ifdef ALU_SERIAL_SHIFT_EN
        if (!m_ill && m_ctrl inside {4'h5, 4'h6, 4'h7} && v.b[4:0] != 5'd0)
            el = 2 + int'(v.b[4:0]);
`endif
        lat = 1;
        while (!bus.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'(el));
        // A competing request while busy must be ignored
        bus.in_valid = 1'b1;
        bus.op_a = ~v.a;
        bus.func = 6'h0C;
        bus.alu_op = 2'b10;
        for (int i = 0; i < v.hold; i++) begin @(posedge clk); #1; end
        chk("held_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        m_busy = 1'b0;
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vq[$];
    logic [3:0]  pc;
    logic        pi;
    logic [31:0] pr;
    int          w;

    initial begin
        bus.in_valid = 1'b0;
        bus.alu_op = 2'b00;
        bus.opcode = 6'h00;
        bus.func = 6'h00;
        bus.op_a = 32'd0;
        bus.op_b = 32'd0;
        bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.alu_op = 2'b00;
        bus16.opcode = 6'h00;
        bus16.func = 6'h00;
        bus16.op_a = 16'd0;
        bus16.op_b = 16'd0;
        bus16.out_ready = 1'b0;

        model(2'b10, 6'h00, 6'h04, 32'd7, 32'd5, pc, pi, pr);
        chk("pin_add", {pr[27:0], pc}, {28'd12, 4'h0});
        model(2'b11, 6'h24, 6'h00, 32'hFFFFFFFF, 32'd1, pc, pi, pr);
        chk("pin_slti", {pr[27:0], pc}, {28'd1, 4'hA});
        model(2'b10, 6'h00, 6'h0F, 32'h80000000, 32'd4, pc, pi, pr);
        chk("pin_sra", pr, 32'hF8000000);
        model(2'b10, 6'h00, 6'h3F, 32'd9, 32'd9, pc, pi, pr);
        chk("pin_illegal", {27'd0, pi, pc}, {27'd0, 1'b1, 4'hF});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        started = 1'b1;

        vq.push_back('{2'b10, 6'h00, 6'h04, 32'd7, 32'd5, 0});
        vq.push_back('{2'b01, 6'h00, 6'h00, 32'd5, 32'd7, 1});
        vq.push_back('{2'b00, 6'h00, 6'h00, 32'hFFFFFFFF, 32'd1, 0});
        vq.push_back('{2'b10, 6'h00, 6'h08, 32'hF0F0_1234, 32'h0FF0_FF00, 0});
        vq.push_back('{2'b10, 6'h00, 6'h09, 32'hF000_0001, 32'h000F_0010, 0});
        vq.push_back('{2'b10, 6'h00, 6'h0A, 32'hAAAA_5555, 32'hFFFF_0000, 0});
        vq.push_back('{2'b10, 6'h00, 6'h0C, 32'd1, 32'd31, 0});
        vq.push_back('{2'b10, 6'h00, 6'h0E, 32'h80000000, 32'd36, 0});
        vq.push_back('{2'b10, 6'h00, 6'h0F, 32'h80000000, 32'd4, 0});
        vq.push_back('{2'b10, 6'h00, 6'h0F, 32'h80000000, 32'd0, 0});
        vq.push_back('{2'b10, 6'h00, 6'h10, 32'd42, 32'd42, 0});
        vq.push_back('{2'b10, 6'h00, 6'h12, 32'd42, 32'd42, 0});
        vq.push_back('{2'b11, 6'h24, 6'h00, 32'hFFFFFFFF, 32'd1, 0});
        vq.push_back('{2'b10, 6'h00, 6'h16, 32'd3, 32'd3, 0});
        vq.push_back('{2'b10, 6'h00, 6'h18, 32'hFFFFFFFF, 32'd1, 0});
        vq.push_back('{2'b10, 6'h00, 6'h1A, 32'h7FFFFFFF, 32'h80000000, 0});
        vq.push_back('{2'b11, 6'h1B, 6'h00, 32'd0, 32'h0000_1234, 0});
        vq.push_back('{2'b11, 6'h14, 6'h00, 32'd100, 32'hFFFFFFFF, 0});
        vq.push_back('{2'b10, 6'h00, 6'h00, 32'd8, 32'd9, 0});
        vq.push_back('{2'b10, 6'h00, 6'h3F, 32'd8, 32'd9, 5});
        vq.push_back('{2'b11, 6'h10, 6'h00, 32'd8, 32'd9, 2});
        foreach (vq[i]) run(vq[i]);

        // Reset in the middle of a long shift
        issue('{2'b10, 6'h00, 6'h0F, 32'h80000000, 32'd20, 0});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_busy = 1'b0;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_ctrl", 32'(bus.alu_ctrl), 32'd0);
        run('{2'b10, 6'h00, 6'h04, 32'd7, 32'd5, 0});

        bus16.alu_op = 2'b11;
        bus16.opcode = 6'h1B;
        bus16.op_a = 16'h1234;
        bus16.op_b = 16'h00AB;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        w = 0;
        while (!bus16.out_valid && w < 20) begin @(posedge clk); #1; w++; end
        chk("w16_valid", 32'(bus16.out_valid), 32'd1);
        chk("w16_lhi", 32'(bus16.result), 32'h0000AB00);
        chk("w16_ctrl", 32'(bus16.alu_ctrl), 32'hE);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        chk("w16_done", 32'(bus16.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
